ternary_dmem_ctrl: RTL and testbench

Parametrised, handshaked ternary data memory that replaces the combinational-read data port with a registered request/response interface. It adds per-tryte write masking, read-before-write responses, explicit error reporting for illegal addresses, and a post-reset zero-fill engine. It sits between the CPU load/store unit and the data store, and is sized by parameters so the same block serves scratchpads and the main data memory.

---
 rtl/ternary_dmem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ternary_dmem_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_dmem_ctrl.sv
// Handshaked ternary data memory: registered request/response port with per-lane
// write masking, read-before-write responses, illegal-address errors and a post-reset zero-fill.
module ternary_dmem_ctrl #(
  parameter int TRIT_WIDTH = 27,
  parameter int DEPTH      = 729,
  parameter int ADDR_TRITS = 9,
  parameter int LANE_TRITS = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [2*ADDR_TRITS-1:0]          req_addr,
  input  logic [2*TRIT_WIDTH-1:0]          req_wdata,
  input  logic [TRIT_WIDTH/LANE_TRITS-1:0] req_mask,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [2*TRIT_WIDTH-1:0]          resp_rdata,
  output logic                             resp_err,
  output logic                             init_busy,
  output logic                             dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response retires on a rising edge where resp_valid && resp_ready. The DUT
  // holds resp_rdata/resp_err stable while resp_valid && !resp_ready.

  localparam int WORD_W = 2 * TRIT_WIDTH;
  localparam int LANES  = TRIT_WIDTH / LANE_TRITS;
  localparam int LANE_W = 2 * LANE_TRITS;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] T_NEG_ONE = 2'b10;
  localparam logic [1:0] T_ZERO    = 2'b00;
  localparam logic [1:0] T_POS_ONE = 2'b01;

  localparam logic [WORD_W-1:0] ZERO_WORD = {TRIT_WIDTH{T_ZERO}};
  localparam logic [AW-1:0]     LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       fill_cnt_q, fill_cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic signed [31:0]  addr_idx;
  logic signed [31:0]  pow3;
  logic                addr_code_bad;
  logic                addr_legal;
  logic [AW-1:0]       acc_idx;
  logic                accept;
  logic [WORD_W-1:0]   old_word;
  logic [WORD_W-1:0]   merged_word;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [WORD_W-1:0]   mem_wdata;

  // Balanced-ternary decode; out-of-range indices are flagged, never wrapped.
  always_comb begin
    addr_idx      = '0;
    pow3          = 32'sd1;
    addr_code_bad = 1'b0;
    for (int i = 0; i < ADDR_TRITS; i++) begin
      case (req_addr[2*i +: 2])
        T_POS_ONE: addr_idx = addr_idx + pow3;
        T_NEG_ONE: addr_idx = addr_idx - pow3;
        T_ZERO:    addr_idx = addr_idx;
        default:   addr_code_bad = 1'b1;
      endcase
      pow3 = pow3 * 32'sd3;
    end
    addr_legal = !addr_code_bad && (addr_idx >= 0) && (addr_idx < DEPTH);
    acc_idx    = addr_legal ? addr_idx[AW-1:0] : '0;
  end

  always_comb begin
    old_word    = mem_q[acc_idx];
    merged_word = old_word;
    for (int k = 0; k < LANES; k++) begin
      if (req_mask[k]) begin
        merged_word[k*LANE_W +: LANE_W] = req_wdata[k*LANE_W +: LANE_W];
      end
    end
  end

  assign req_ready = (state_q == ST_RUN) && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;
    mem_waddr    = acc_idx;
    mem_wdata    = merged_word;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = fill_cnt_q;
        mem_wdata = ZERO_WORD;
        if (fill_cnt_q == LAST_IDX) begin
          state_d    = ST_RUN;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (accept) begin
          resp_valid_d = 1'b1;
          resp_err_d   = !addr_legal;
          resp_rdata_d = addr_legal ? old_word : ZERO_WORD;
          // An all-zero mask rewrites the old word, so memory is unchanged.
          mem_we       = req_we && addr_legal;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      fill_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= ZERO_WORD;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage has no reset; the INIT sweep provides the zero contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign init_busy  = (state_q == ST_INIT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ternary_dmem_ctrl.sv
// Bench for ternary_dmem_ctrl: directed requests push expected {err, rdata} into a
// queue; a negedge monitor pops and compares each response as it retires.
module tb_ternary_dmem_ctrl;

  localparam int TW = 27;
  localparam int AT = 9;
  localparam int LANES = 9;
  localparam int WW = 2 * TW;
  localparam int W = WW + 1;

  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2*AT-1:0]   req_addr;
  logic [WW-1:0]     req_wdata;
  logic [LANES-1:0]  req_mask;
  logic              resp_valid;
  logic              resp_ready;
  logic [WW-1:0]     resp_rdata;
  logic              resp_err;
  logic              init_busy;
  logic              dbg_state;

  ternary_dmem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_mask   (req_mask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_busy  (init_busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int pop_cyc_q[$];
  logic [W-1:0] mon_exp;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got %h with no expected entry", {resp_err, resp_rdata});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("resp", {resp_err, resp_rdata}, mon_exp);
      end
      pop_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [2*AT-1:0] addr, input logic [WW-1:0] wd,
                      input logic [LANES-1:0] mask, input logic err, input logic [WW-1:0] exp_rd);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_mask  = mask;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("accept_timeout", W'(req_ready), W'(1));
      req_valid = 1'b0;
    end else begin
      exp_q.push_back({err, exp_rd});
      sync();
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_queue", W'(exp_q.size()), W'(0));
    sync();
  endtask

  task automatic release_and_count(output int n);
    sync();
    rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (init_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    sync();
  endtask

  function automatic logic [WW-1:0] pat(int s);
    logic [WW-1:0] w;
    w = '0;
    for (int j = 0; j < TW; j++) begin
      case ((s + j) % 3)
        0:       w[2*j +: 2] = T_NEG;
        1:       w[2*j +: 2] = T_ZERO;
        default: w[2*j +: 2] = T_POS;
      endcase
    end
    return w;
  endfunction

  // ---------------- stimulus ----------------
  logic [WW-1:0]   all_pos, all_neg, mix;
  logic [2*AT-1:0] addr_tab [10];
  logic [WW-1:0]   shadow [10];
  int              busy_n;
  int              base;

  initial begin
    all_pos = {TW{T_POS}};
    all_neg = {TW{T_NEG}};
    mix = all_pos;
    mix[5:0] = {T_NEG, T_NEG, T_NEG};
    addr_tab[0] = 18'h00000; addr_tab[1] = 18'h00001; addr_tab[2] = 18'h00006;
    addr_tab[3] = 18'h00004; addr_tab[4] = 18'h00005; addr_tab[5] = 18'h0001A;
    addr_tab[6] = 18'h00018; addr_tab[7] = 18'h00019; addr_tab[8] = 18'h00012;
    addr_tab[9] = 18'h00010;
    for (int i = 0; i < 10; i++) shadow[i] = '0;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_mask = '0; resp_ready = 1'b1;
    #2;
    chk("rst_req_ready",  W'(req_ready),  W'(0));
    chk("rst_init_busy",  W'(init_busy),  W'(1));
    chk("rst_resp_valid", W'(resp_valid), W'(0));
    chk("rst_resp_err",   W'(resp_err),   W'(0));
    chk("rst_resp_rdata", W'(resp_rdata), W'(0));
    sync();

    release_and_count(busy_n);
    chk("init_cycles", W'(busy_n), W'(729));

    // last index after fill
    send(1'b0, 18'h01002, '0, '0, 1'b0, '0);

    // masked writes with read-before-write at index 4
    send(1'b1, 18'h00005, all_pos, 9'h1FF, 1'b0, '0);
    send(1'b1, 18'h00005, all_neg, 9'h001, 1'b0, all_pos);
    send(1'b0, 18'h00005, '0, '0, 1'b0, mix);
    shadow[4] = mix;
    // all-zero mask write: no change, still a response
    send(1'b1, 18'h00005, all_neg, 9'h000, 1'b0, mix);

    // illegal addresses
    send(1'b0, 18'h00002, '0, '0, 1'b1, '0);
    send(1'b1, 18'h01000, all_pos, 9'h1FF, 1'b1, '0);
    send(1'b1, 18'h00003, all_neg, 9'h1FF, 1'b1, '0);
    send(1'b0, 18'h00000, '0, '0, 1'b0, '0);
    wait_idle();

    // backpressure: hold the response, keep a second request pending
    resp_ready = 1'b0;
    send(1'b0, 18'h00005, '0, '0, 1'b0, mix);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", W'(resp_valid), W'(1));
      chk("bp_rdata_hold", {resp_err, resp_rdata}, {1'b0, mix});
      chk("bp_req_ready",  W'(req_ready), W'(0));
    end
    sync();
    resp_ready = 1'b1;
    send(1'b0, 18'h00000, '0, '0, 1'b0, '0);
    wait_idle();

    // streaming: 20 alternating writes/reads, responses in 20 consecutive cycles
    base = pop_cyc_q.size();
    for (int i = 0; i < 10; i++) begin
      send(1'b1, addr_tab[i], pat(i), 9'h1FF, 1'b0, shadow[i]);
      shadow[i] = pat(i);
      send(1'b0, addr_tab[i], '0, '0, 1'b0, pat(i));
    end
    wait_idle();
    chk("stream_count", W'(pop_cyc_q.size() - base), W'(20));
    if (pop_cyc_q.size() - base >= 20)
      chk("stream_span", W'(pop_cyc_q[base+19] - pop_cyc_q[base]), W'(19));

    // reset in the middle of a stream
    send(1'b1, addr_tab[3], pat(7), 9'h1FF, 1'b0, shadow[3]);
    send(1'b0, addr_tab[3], '0, '0, 1'b0, pat(7));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", W'(resp_valid), W'(0));
    chk("midrst_req_ready",  W'(req_ready),  W'(0));
    chk("midrst_init_busy",  W'(init_busy),  W'(1));
    exp_q.delete();
    sync();
    release_and_count(busy_n);
    chk("reinit_cycles", W'(busy_n), W'(729));
    send(1'b0, addr_tab[3], '0, '0, 1'b0, '0);
    send(1'b0, addr_tab[4], '0, '0, 1'b0, '0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
